ram_col_frame_strobe_seq: RTL and testbench
===========================================

Name: ram_col_frame_strobe_seq

Overview:
- Per-column configuration sequencer for a RAM column of the fabric.
- Accepts frame-write requests from the global configuration controller and drives the column's FrameData and one-hot FrameStrobe bus.
- The FrameStrobe bus enters at the south end of the column, passes tile to tile, and terminates in the north RAM I/O terminal tile.
- Guarantees data setup before the strobe, a bounded strobe width, and data hold after the strobe, so frame latches in every tile capture cleanly.

Parameters:
- MaxFramesPerCol, 20, width of the FrameStrobe bus (frames per column).
- FrameBitsPerRow, 32, frame bits per tile row.
- NumRows, 4, tile rows in the column; FrameData width = FrameBitsPerRow*NumRows.
- ColId, 0, this column's address (8-bit compare).
- SetupCycles, 1, cycles FrameData is stable before the strobe (legal 0..15).
- StrobeCycles, 1, strobe high width in cycles (legal 1..15).
- HoldCycles, 1, cycles FrameData is stable after the strobe falls (legal 0..15).

Ports:
- UserCLK  input  1  clock for all state.
- reset  input  1  synchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  request accepted when req_valid && req_ready.
- req_col  input  8  target column.
- req_frame  input  8  frame index.
- req_data  input  FrameBitsPerRow*NumRows  frame payload.
- FrameData  output  FrameBitsPerRow*NumRows  registered payload to the column.
- FrameStrobe  output  MaxFramesPerCol  one-hot registered strobe to the column.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse on the last HOLD cycle.
- err_range  output  1  sticky; set on an in-column request with req_frame >= MaxFramesPerCol.
- frames_written  output  16  count of completed strobes; saturates at 0xFFFF.

Behaviour:
- Reset values, taking effect at the first edge with reset=1:
  - FSM state = IDLE.
  - FrameData = 0, FrameStrobe = 0.
  - done = 0, err_range = 0, frames_written = 0.
- Reset asserted mid-sequence drops FrameStrobe to 0 on that same edge; the in-flight frame is abandoned and not counted.
- States: IDLE, SETUP, STROBE, HOLD. All outputs are registered.
- req_ready = 1 only in IDLE with reset low. This is a combinational decode of the state, not of req_valid.
- Acceptance in IDLE:
  - req_col != ColId: accept (ready=1), drop silently, stay IDLE. FrameData is unchanged.
  - req_col == ColId and req_frame >= MaxFramesPerCol: accept, set err_range, stay IDLE. FrameData is unchanged.
  - Otherwise: latch req_data into FrameData and req_frame into an internal index register, load the cycle counter, then:
    - SetupCycles > 0: go to SETUP.
    - SetupCycles = 0: go to STROBE, with FrameStrobe[index] rising on that same edge together with FrameData.
- SETUP: stays SetupCycles cycles. On exit, FrameStrobe[index] = 1 and the state is STROBE.
- STROBE: exactly one strobe bit is high for StrobeCycles cycles. On exit, FrameStrobe = 0, frames_written increments (saturating), and then:
  - HoldCycles > 0: go to HOLD.
  - HoldCycles = 0: go to IDLE with done = 1 for one cycle.
- HOLD: stays HoldCycles cycles with FrameData unchanged. The final cycle asserts done; the next state is IDLE.
- Latency: with S/T/H = SetupCycles/StrobeCycles/HoldCycles, an accepted request leaves IDLE for exactly S+T+H cycles; on that path the state is in IDLE again after S+T+H cycles. The next request can be accepted on the first IDLE cycle.
- FrameData is held until the next accepted in-column, in-range request; it is not cleared at IDLE.
- Invariants: at most one FrameStrobe bit is ever high; FrameStrobe is never high outside STROBE.
- Bus checks: req_* are don't-care when req_valid = 0. A change in req_* while busy has no effect.
- Counter width: 4 bits, sufficient for parameters up to 15.

Test Plan:
- Defaults (S/T/H=1/1/1), request col=0 frame=5 data=0xA5A5... → FrameData=0xA5A5... one cycle after accept; FrameStrobe=0x00020 for exactly 1 cycle, starting 2 cycles after accept; done 3 cycles after accept; frames_written=1.
- Request col=3 with ColId=0 → accepted, FrameStrobe stays 0, FrameData unchanged, err_range=0, frames_written unchanged.
- Request col=0 frame=20 → err_range=1 and sticky until reset; no strobe; a following valid frame=19 request strobes bit 19 (0x80000).
- SetupCycles=0, StrobeCycles=3, HoldCycles=0, back-to-back requests frames 0 and 1 → strobe 0x1 high for 3 cycles, then 0x2 high for 3 cycles; req_ready low throughout each 3-cycle strobe; gap of exactly one IDLE cycle between strobes.
- Assert reset during STROBE of frame 7 → FrameStrobe=0 at that edge, frames_written=0, busy=0, req_ready=1 after reset releases.
- 65540 completed writes (or a forced counter preload near 0xFFFF) → frames_written saturates at 0xFFFF; invariant check: popcount(FrameStrobe) ≤ 1 every cycle.

Source files
------------

// File: rtl/ram_col_frame_strobe_seq.sv
// ram_col_frame_strobe_seq
// ------------------------
// Configuration sequencer for one RAM column of the fabric. It accepts frame
// write requests from the global configuration controller. For each accepted
// request it drives the column-wide FrameData bus and one bit of the one-hot
// FrameStrobe bus. FrameStrobe enters at the south end of the column and ends
// in the north RAM I/O terminal tile.
//
// Every frame write follows the same fixed timeline:
//   1. SETUP  : FrameData is stable for SetupCycles cycles before the strobe.
//   2. STROBE : FrameStrobe[frame] is high for exactly StrobeCycles cycles.
//   3. HOLD   : FrameData stays stable for HoldCycles cycles after the strobe.
// This lets the frame latches in every tile of the column capture cleanly.
//
// Ports
//   UserCLK        clock for all state
//   reset          synchronous, active-high
//   req_valid      a request is present
//   req_ready      request accepted when req_valid && req_ready (IDLE only)
//   req_col        target column; requests for other columns are dropped
//   req_frame      frame index; values >= MaxFramesPerCol set err_range
//   req_data       frame payload
//   FrameData      registered payload to the column (held between writes)
//   FrameStrobe    registered one-hot strobe to the column
//   busy           high whenever the sequencer is not IDLE
//   done           one-cycle pulse on the last cycle of a write
//   err_range      sticky out-of-range frame flag, cleared only by reset
//   frames_written count of completed strobes, saturating at 0xFFFF

module ram_col_frame_strobe_seq #(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NumRows         = 4,
    parameter int ColId           = 0,
    parameter int SetupCycles     = 1,
    parameter int StrobeCycles    = 1,
    parameter int HoldCycles      = 1
) (
    input  logic                               UserCLK,
    input  logic                               reset,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic [7:0]                         req_col,
    input  logic [7:0]                         req_frame,
    input  logic [FrameBitsPerRow*NumRows-1:0] req_data,
    output logic [FrameBitsPerRow*NumRows-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0]         FrameStrobe,
    output logic                               busy,
    output logic                               done,
    output logic                               err_range,
    output logic [15:0]                        frames_written
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // The counter holds "cycles remaining minus one" in the current phase.
    // A phase therefore ends when the counter reads zero.
    localparam logic [3:0] SETUP_LOAD  = 4'((SetupCycles > 0) ? SetupCycles - 1 : 0);
    localparam logic [3:0] STROBE_LOAD = 4'((StrobeCycles > 0) ? StrobeCycles - 1 : 0);
    localparam logic [3:0] HOLD_LOAD   = 4'((HoldCycles > 0) ? HoldCycles - 1 : 0);
    localparam logic [7:0] COL_ID      = 8'(ColId);

    state_t                             state_q, state_d;
    logic [FrameBitsPerRow*NumRows-1:0] data_q, data_d;
    logic [MaxFramesPerCol-1:0]         strobe_q, strobe_d;
    logic [7:0]                         idx_q, idx_d;
    logic [3:0]                         cnt_q, cnt_d;
    logic                               done_q, done_d;
    logic                               err_q, err_d;
    logic [15:0]                        frames_q, frames_d;

    logic                               req_in_range;

    // Two one-hot decodes are needed.
    //   idx_onehot comes from the latched index and is used when leaving SETUP.
    //   req_onehot comes straight from the request. It is used only when
    //   SetupCycles is zero: the strobe must then rise on the accept edge,
    //   before the index register has been written.
    logic [MaxFramesPerCol-1:0]         idx_onehot;
    logic [MaxFramesPerCol-1:0]         req_onehot;

    generate
        for (genvar gi = 0; gi < MaxFramesPerCol; gi++) begin : g_onehot
            assign idx_onehot[gi] = (idx_q == 8'(gi));
            assign req_onehot[gi] = (req_frame == 8'(gi));
        end
    endgenerate

    assign req_in_range = (int'(req_frame) < MaxFramesPerCol);

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        strobe_d = strobe_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        err_d    = err_q;
        frames_d = frames_q;

        case (state_q)
            IDLE: begin
                if (req_valid && (req_col == COL_ID)) begin
                    if (req_in_range) begin
                        data_d = req_data;
                        idx_d  = req_frame;
                        if (SetupCycles > 0) begin
                            state_d = SETUP;
                            cnt_d   = SETUP_LOAD;
                        end else begin
                            state_d  = STROBE;
                            cnt_d    = STROBE_LOAD;
                            strobe_d = req_onehot;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
                // A request for another column is consumed without any effect.
            end

            SETUP: begin
                if (cnt_q == 4'd0) begin
                    state_d  = STROBE;
                    cnt_d    = STROBE_LOAD;
                    strobe_d = idx_onehot;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            STROBE: begin
                if (cnt_q == 4'd0) begin
                    strobe_d = '0;
                    frames_d = (frames_q == 16'hFFFF) ? frames_q : frames_q + 16'd1;
                    if (HoldCycles > 0) begin
                        state_d = HOLD;
                        cnt_d   = HOLD_LOAD;
                        // A single hold cycle is also the last cycle of the write.
                        done_d  = (HoldCycles == 1);
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            HOLD: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d  = cnt_q - 4'd1;
                    // done is registered. Raise it on entry to the last hold cycle.
                    done_d = (cnt_q == 4'd1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge UserCLK) begin
        if (reset) begin
            state_q  <= IDLE;
            data_q   <= '0;
            strobe_q <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            frames_q <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            strobe_q <= strobe_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
            frames_q <= frames_d;
        end
    end

    assign req_ready      = (state_q == IDLE) && !reset;
    assign busy           = (state_q != IDLE);
    assign FrameData      = data_q;
    assign FrameStrobe    = strobe_q;
    assign done           = done_q;
    assign err_range      = err_q;
    assign frames_written = frames_q;

endmodule

// File: tb/tb_ram_col_frame_strobe_seq.sv
// Testbench for ram_col_frame_strobe_seq.
//   dut_a uses the default timing S/T/H = 1/1/1.
//   dut_b uses S/T/H = 0/3/0 for the back-to-back sequence and the reset
//   corner cases.
// Every transaction prints one line. Each failed comparison prints a FAIL line.

module tb_ram_col_frame_strobe_seq;

    localparam int DW = 128;
    localparam int FW = 20;

    logic          clk;
    logic          rst_a, rst_b;

    logic          req_valid_a, req_ready_a;
    logic [7:0]    req_col_a, req_frame_a;
    logic [DW-1:0] req_data_a, frame_data_a;
    logic [FW-1:0] strobe_a;
    logic          busy_a, done_a, err_a;
    logic [15:0]   frames_a;

    logic          req_valid_b, req_ready_b;
    logic [7:0]    req_col_b, req_frame_b;
    logic [DW-1:0] req_data_b, frame_data_b;
    logic [FW-1:0] strobe_b;
    logic          busy_b, done_b, err_b;
    logic [15:0]   frames_b;

    int total = 0;
    int bad   = 0;
    logic mon_en = 1'b0;

    ram_col_frame_strobe_seq dut_a (
        .UserCLK        (clk),
        .reset          (rst_a),
        .req_valid      (req_valid_a),
        .req_ready      (req_ready_a),
        .req_col        (req_col_a),
        .req_frame      (req_frame_a),
        .req_data       (req_data_a),
        .FrameData      (frame_data_a),
        .FrameStrobe    (strobe_a),
        .busy           (busy_a),
        .done           (done_a),
        .err_range      (err_a),
        .frames_written (frames_a)
    );

    ram_col_frame_strobe_seq #(
        .SetupCycles  (0),
        .StrobeCycles (3),
        .HoldCycles   (0)
    ) dut_b (
        .UserCLK        (clk),
        .reset          (rst_b),
        .req_valid      (req_valid_b),
        .req_ready      (req_ready_b),
        .req_col        (req_col_b),
        .req_frame      (req_frame_b),
        .req_data       (req_data_b),
        .FrameData      (frame_data_b),
        .FrameStrobe    (strobe_b),
        .busy           (busy_b),
        .done           (done_b),
        .err_range      (err_b),
        .frames_written (frames_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Invariants, checked every cycle on the falling edge:
    //   - at most one strobe bit is high
    //   - no strobe is high while the sequencer is idle
    always @(negedge clk) begin
        if (mon_en) begin
            chk("onehot_a", DW'($countones(strobe_a) <= 1), DW'(1));
            chk("strobe_idle_a", DW'((strobe_a != '0) && !busy_a), DW'(0));
            chk("onehot_b", DW'($countones(strobe_b) <= 1), DW'(1));
            chk("strobe_idle_b", DW'((strobe_b != '0) && !busy_b), DW'(0));
        end
    end

    typedef struct {
        logic [7:0]    col;
        logic [7:0]    frame;
        logic [DW-1:0] data;
        logic [FW-1:0] exp_strobe;
        logic          exp_busy;
        logic [DW-1:0] exp_data;
        logic          exp_err;
        logic [15:0]   exp_frames;
    } vec_t;

    // One request on dut_a (S/T/H = 1/1/1). Expected timeline, counted in
    // cycles after the accept edge:
    //   cycle 1: busy, FrameData = new data, strobe 0
    //   cycle 2: strobe high
    //   cycle 3: done high, strobe 0
    //   cycle 4: IDLE again
    task automatic run_vec(input vec_t v, input int n);
        string t;
        t = $sformatf("v%0d", n);
        @(negedge clk);
        req_valid_a = 1'b1;
        req_col_a   = v.col;
        req_frame_a = v.frame;
        req_data_a  = v.data;
        chk({t, " ready"}, DW'(req_ready_a), DW'(1));
        @(posedge clk);
        @(negedge clk);
        req_valid_a = 1'b0;
        chk({t, " busy_c1"}, DW'(busy_a), DW'(v.exp_busy));
        chk({t, " data_c1"}, frame_data_a, v.exp_data);
        chk({t, " strobe_c1"}, DW'(strobe_a), DW'(0));
        @(negedge clk);
        chk({t, " strobe_c2"}, DW'(strobe_a), DW'(v.exp_strobe));
        chk({t, " done_c2"}, DW'(done_a), DW'(0));
        @(negedge clk);
        chk({t, " done_c3"}, DW'(done_a), DW'(v.exp_busy));
        chk({t, " strobe_c3"}, DW'(strobe_a), DW'(0));
        @(negedge clk);
        chk({t, " busy_c4"}, DW'(busy_a), DW'(0));
        chk({t, " ready_c4"}, DW'(req_ready_a), DW'(1));
        chk({t, " done_c4"}, DW'(done_a), DW'(0));
        chk({t, " err"}, DW'(err_a), DW'(v.exp_err));
        chk({t, " frames"}, DW'(frames_a), DW'(v.exp_frames));
        chk({t, " data_c4"}, frame_data_a, v.exp_data);
        $display("txn %s col=%0d frame=%0d strobe=%h err=%0d frames=%h",
                 t, v.col, v.frame, strobe_a, err_a, frames_a);
    endtask

    initial begin
        vec_t vecs[7];
        vec_t sat[3];
        logic [DW-1:0] d1, d2, d3, d4;
        logic [FW-1:0] exp_sb[8];
        logic          exp_rb[8];
        logic          exp_db[8];

        d1 = {4{32'hA5A5A5A5}};
        d2 = {4{32'h12345678}};
        d3 = {4{32'h0F1E2D3C}};
        d4 = {32'hDEADBEEF, 32'h00000000, 32'hFFFFFFFF, 32'h01234567};

        //            col    frame   data  strobe      busy  exp_data err frames
        vecs[0] = '{8'd0, 8'd5,   d1, 20'h00020, 1'b1, d1, 1'b0, 16'd1};
        vecs[1] = '{8'd3, 8'd2,   d2, 20'h00000, 1'b0, d1, 1'b0, 16'd1};
        vecs[2] = '{8'd0, 8'd20,  d2, 20'h00000, 1'b0, d1, 1'b1, 16'd1};
        vecs[3] = '{8'd0, 8'd19,  d3, 20'h80000, 1'b1, d3, 1'b1, 16'd2};
        vecs[4] = '{8'd1, 8'd0,   d1, 20'h00000, 1'b0, d3, 1'b1, 16'd2};
        vecs[5] = '{8'd0, 8'd255, d2, 20'h00000, 1'b0, d3, 1'b1, 16'd2};
        vecs[6] = '{8'd0, 8'd0,   d4, 20'h00001, 1'b1, d4, 1'b1, 16'd3};

        // Writes after frames_written has been preloaded to 0xFFFD.
        sat[0] = '{8'd0, 8'd10, d1, 20'h00400, 1'b1, d1, 1'b1, 16'hFFFE};
        sat[1] = '{8'd0, 8'd11, d2, 20'h00800, 1'b1, d2, 1'b1, 16'hFFFF};
        sat[2] = '{8'd0, 8'd12, d3, 20'h01000, 1'b1, d3, 1'b1, 16'hFFFF};

        // dut_b back-to-back timeline, cycles 1..8 after the first accept.
        exp_sb = '{20'h1, 20'h1, 20'h1, 20'h0, 20'h2, 20'h2, 20'h2, 20'h0};
        exp_rb = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        exp_db = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

        rst_a = 1'b1; rst_b = 1'b1;
        req_valid_a = 1'b0; req_col_a = '0; req_frame_a = '0; req_data_a = '0;
        req_valid_b = 1'b0; req_col_b = '0; req_frame_b = '0; req_data_b = '0;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst ready_a", DW'(req_ready_a), DW'(0));
        chk("rst data_a", frame_data_a, DW'(0));
        chk("rst strobe_a", DW'(strobe_a), DW'(0));
        chk("rst busy_a", DW'(busy_a), DW'(0));
        chk("rst done_a", DW'(done_a), DW'(0));
        chk("rst err_a", DW'(err_a), DW'(0));
        chk("rst frames_a", DW'(frames_a), DW'(0));
        chk("rst ready_b", DW'(req_ready_b), DW'(0));
        chk("rst strobe_b", DW'(strobe_b), DW'(0));
        rst_a = 1'b0; rst_b = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        chk("post-rst ready_a", DW'(req_ready_a), DW'(1));
        $display("txn reset released");

        // Table-driven vectors on dut_a.
        for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

        // Preload the counter near saturation, then check that it saturates.
        @(negedge clk);
        force dut_a.frames_q = 16'hFFFD;
        @(negedge clk);
        release dut_a.frames_q;
        @(negedge clk);
        chk("preload frames", DW'(frames_a), DW'(16'hFFFD));
        for (int i = 0; i < 3; i++) run_vec(sat[i], 10 + i);

        // dut_b: back-to-back frames 0 and 1 with S/T/H = 0/3/0.
        @(negedge clk);
        req_valid_b = 1'b1;
        req_col_b   = 8'd0;
        req_frame_b = 8'd0;
        req_data_b  = d1;
        chk("b2b ready0", DW'(req_ready_b), DW'(1));
        @(posedge clk);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_frame_b = 8'd1;
                req_data_b  = d2;
            end
            if (c == 5) req_valid_b = 1'b0;
            chk($sformatf("b2b strobe_c%0d", c), DW'(strobe_b), DW'(exp_sb[c-1]));
            chk($sformatf("b2b ready_c%0d", c), DW'(req_ready_b), DW'(exp_rb[c-1]));
            chk($sformatf("b2b done_c%0d", c), DW'(done_b), DW'(exp_db[c-1]));
            $display("txn b2b cycle=%0d strobe=%h ready=%0d done=%0d",
                     c, strobe_b, req_ready_b, done_b);
        end
        chk("b2b frames", DW'(frames_b), DW'(2));
        chk("b2b data", frame_data_b, d2);

        // dut_b: reset while frame 7 is in STROBE.
        @(negedge clk);
        req_valid_b = 1'b1;
        req_frame_b = 8'd7;
        req_data_b  = d3;
        @(posedge clk);
        @(negedge clk);
        req_valid_b = 1'b0;
        chk("rstmid strobe_c1", DW'(strobe_b), DW'(20'h00080));
        rst_b = 1'b1;
        @(negedge clk);
        chk("rstmid strobe", DW'(strobe_b), DW'(0));
        chk("rstmid frames", DW'(frames_b), DW'(0));
        chk("rstmid busy", DW'(busy_b), DW'(0));
        chk("rstmid ready_in_rst", DW'(req_ready_b), DW'(0));
        chk("rstmid data", frame_data_b, DW'(0));
        rst_b = 1'b0;
        @(negedge clk);
        chk("rstmid ready_after", DW'(req_ready_b), DW'(1));
        chk("rstmid busy_after", DW'(busy_b), DW'(0));
        chk("rstmid strobe_after", DW'(strobe_b), DW'(0));
        $display("txn reset during strobe frame=7 frames=%0d", frames_b);

        @(negedge clk);
        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
